// File: rtl/cluster_cmd_arbiter_if.sv
// Command, completion and status bundle between the HPU drivers, the cluster
// command arbiter and the cluster command engine.
interface cluster_cmd_arbiter_if #(
    parameter int unsigned NUM_HPUS = 8,
    parameter int unsigned CMD_W    = 128,
    parameter int unsigned ID_W     = 40,
    parameter int unsigned CNT_W    = 4
);
    logic [NUM_HPUS-1:0]       hpu_cmd_valid_i;
    logic [NUM_HPUS-1:0]       hpu_cmd_ready_o;
    logic [NUM_HPUS*ID_W-1:0]  hpu_cmd_id_i;
    logic [NUM_HPUS*CMD_W-1:0] hpu_cmd_data_i;
    logic                      engine_cmd_valid_o;
    logic                      engine_cmd_ready_i;
    logic [ID_W-1:0]           engine_cmd_id_o;
    logic [CMD_W-1:0]          engine_cmd_data_o;
    logic                      engine_resp_valid_i;
    logic [ID_W-1:0]           engine_resp_id_i;
    logic                      cmd_resp_valid_o;
    logic [ID_W-1:0]           cmd_resp_id_o;
    logic [NUM_HPUS-1:0]       hpu_idle_o;
    logic [CNT_W-1:0]          outstanding_o;
    logic                      err_o;

    modport slave (
        input  hpu_cmd_valid_i, hpu_cmd_id_i, hpu_cmd_data_i,
               engine_cmd_ready_i, engine_resp_valid_i, engine_resp_id_i,
        output hpu_cmd_ready_o, engine_cmd_valid_o, engine_cmd_id_o, engine_cmd_data_o,
               cmd_resp_valid_o, cmd_resp_id_o, hpu_idle_o, outstanding_o, err_o
    );

    modport master (
        output hpu_cmd_valid_i, hpu_cmd_id_i, hpu_cmd_data_i,
               engine_cmd_ready_i, engine_resp_valid_i, engine_resp_id_i,
        input  hpu_cmd_ready_o, engine_cmd_valid_o, engine_cmd_id_o, engine_cmd_data_o,
               cmd_resp_valid_o, cmd_resp_id_o, hpu_idle_o, outstanding_o, err_o
    );
endinterface

// File: rtl/cluster_cmd_arbiter.sv
// Round-robin merge of per-HPU command streams into one registered engine stream,
// with a cluster-wide credit limit, per-HPU outstanding tracking and completion broadcast.
module cluster_cmd_arbiter #(
    parameter int unsigned NUM_HPUS        = 8,
    parameter int unsigned CMD_W           = 128,
    parameter int unsigned ID_W            = 40,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [15:0]          cluster_id_i,
    cluster_cmd_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (NUM_HPUS > 1) ? $clog2(NUM_HPUS) : 1;

    logic [PTR_W-1:0]    rr_ptr, grant_idx, idx_p;
    logic [NUM_HPUS-1:0] grant;
    logic                grant_any, credit_ok, can_load;
    logic                cmd_valid;
    logic [ID_W-1:0]     cmd_id;
    logic [CMD_W-1:0]    cmd_data;
    logic                resp_valid;
    logic [ID_W-1:0]     resp_id;
    logic [CNT_W-1:0]    outstanding;
    logic [CNT_W-1:0]    hpu_cnt [NUM_HPUS];
    logic                err;
    logic [NUM_HPUS-1:0] inc, dec;
    logic [15:0]         issue_core, resp_core;
    logic                issue, issue_hit, resp_match, comp, comp_drop, err_set;
    int unsigned         idx;

    // A command sitting in the output register holds a credit even before it issues.
    assign credit_ok = ({1'b0, outstanding} + (CNT_W+1)'(cmd_valid)) < (CNT_W+1)'(MAX_OUTSTANDING);
    assign can_load  = (!cmd_valid || bus.engine_cmd_ready_i) && credit_ok;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        idx_p     = '0;
        if (can_load) begin
            for (int unsigned k = 0; k < NUM_HPUS; k++) begin
                idx   = (int'(rr_ptr) + k) % NUM_HPUS;
                idx_p = PTR_W'(idx);
                if (!grant_any && bus.hpu_cmd_valid_i[idx_p]) begin
                    grant[idx_p] = 1'b1;
                    grant_idx    = idx_p;
                    grant_any    = 1'b1;
                end
            end
        end
    end

    assign issue      = cmd_valid && bus.engine_cmd_ready_i;
    assign issue_core = cmd_id[23:8];
    assign issue_hit  = issue_core < 16'(NUM_HPUS);
    assign resp_core  = bus.engine_resp_id_i[23:8];
    assign resp_match = bus.engine_resp_id_i[ID_W-1 -: 16] == cluster_id_i;
    assign comp       = bus.engine_resp_valid_i && resp_match && (outstanding != '0);
    assign comp_drop  = bus.engine_resp_valid_i && !(resp_match && (outstanding != '0));

    always_comb begin
        inc = '0;
        dec = '0;
        for (int unsigned i = 0; i < NUM_HPUS; i++) begin
            inc[i] = issue && (issue_core == 16'(i));
            dec[i] = comp && (resp_core == 16'(i)) && (hpu_cnt[i] != '0);
        end
    end

    // A valid completion that finds no per-HPU count to retire still retires the global credit.
    assign err_set = (issue && !issue_hit) || comp_drop || (comp && !(|dec));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr      <= '0;
            cmd_valid   <= 1'b0;
            cmd_id      <= '0;
            cmd_data    <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            outstanding <= '0;
            err         <= 1'b0;
            for (int unsigned i = 0; i < NUM_HPUS; i++) hpu_cnt[i] <= '0;
        end else begin
            if (grant_any) begin
                cmd_valid <= 1'b1;
                cmd_id    <= bus.hpu_cmd_id_i[grant_idx*ID_W +: ID_W];
                cmd_data  <= bus.hpu_cmd_data_i[grant_idx*CMD_W +: CMD_W];
                rr_ptr    <= (grant_idx == PTR_W'(NUM_HPUS - 1)) ? '0 : grant_idx + 1'b1;
            end else if (bus.engine_cmd_ready_i) begin
                cmd_valid <= 1'b0;
            end
            resp_valid <= comp;
            if (comp) resp_id <= bus.engine_resp_id_i;
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(comp);
            for (int unsigned i = 0; i < NUM_HPUS; i++)
                hpu_cnt[i] <= hpu_cnt[i] + CNT_W'(inc[i]) - CNT_W'(dec[i]);
            if (err_set) err <= 1'b1;
        end
    end

    always_comb begin
        bus.hpu_idle_o = '0;
        for (int unsigned i = 0; i < NUM_HPUS; i++) bus.hpu_idle_o[i] = (hpu_cnt[i] == '0);
    end

    assign bus.hpu_cmd_ready_o    = grant;
    assign bus.engine_cmd_valid_o = cmd_valid;
    assign bus.engine_cmd_id_o    = cmd_id;
    assign bus.engine_cmd_data_o  = cmd_data;
    assign bus.cmd_resp_valid_o   = resp_valid;
    assign bus.cmd_resp_id_o      = resp_id;
    assign bus.outstanding_o      = outstanding;
    assign bus.err_o              = err;
endmodule

// File: tb/tb_cluster_cmd_arbiter.sv
// Scoreboard bench for cluster_cmd_arbiter: engine-side issues and completion
// broadcasts are matched against queues filled as stimulus is planned.
module tb_cluster_cmd_arbiter;
    localparam int unsigned N = 8, CMD_W = 128, ID_W = 40, MAXO = 8, CNT_W = 4;
    localparam logic [15:0] CL = 16'h1234, FOREIGN = 16'h4321;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [CMD_W-1:0] data;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cluster_cmd_arbiter_if #(.NUM_HPUS(N), .CMD_W(CMD_W), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

    cluster_cmd_arbiter #(.NUM_HPUS(N), .CMD_W(CMD_W), .ID_W(ID_W), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .cluster_id_i(CL), .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [7:0]        seq     [N];
    logic [7:0]        exp_seq [N];
    logic [N-1:0]      take;
    logic [N*ID_W-1:0]  id_flat;
    logic [N*CMD_W-1:0] data_flat;
    cmd_t              cmd_q  [$];
    logic [ID_W-1:0]   resp_q [$];

    function automatic logic [ID_W-1:0] mk_id(int unsigned h, logic [7:0] s);
        return {CL, 16'(h), s};
    endfunction

    function automatic logic [CMD_W-1:0] mk_data(int unsigned h, logic [7:0] s);
        return {32'hC0DE_0000 | 32'(h), 24'h0, s, 32'(h * 7 + 1), ~{24'h0, s}};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input int unsigned h);
        cmd_q.push_back(cmd_t'{mk_id(h, exp_seq[h]), mk_data(h, exp_seq[h])});
        exp_seq[h] = exp_seq[h] + 8'd1;
    endtask

    task automatic resp(input logic [15:0] cl, input int unsigned core, input logic [7:0] lid, input bit want);
        bus.engine_resp_valid_i = 1'b1;
        bus.engine_resp_id_i    = {cl, 16'(core), lid};
        if (want) resp_q.push_back({cl, 16'(core), lid});
        cyc(1);
        bus.engine_resp_valid_i = 1'b0;
    endtask

    // HPU sources: each presents its next command until it is accepted
    always_comb begin
        id_flat   = '0;
        data_flat = '0;
        for (int i = 0; i < N; i++) begin
            id_flat[i*ID_W +: ID_W]    = mk_id(i, seq[i]);
            data_flat[i*CMD_W +: CMD_W] = mk_data(i, seq[i]);
        end
    end
    assign bus.hpu_cmd_id_i   = id_flat;
    assign bus.hpu_cmd_data_i = data_flat;

    always @(negedge clk) take <= bus.hpu_cmd_valid_i & bus.hpu_cmd_ready_o;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst_n) seq[i] <= 8'd0;
            else if (take[i]) seq[i] <= seq[i] + 8'd1;
        end
    end

    always @(negedge clk) begin
        cmd_t e;
        if (rst_n && bus.engine_cmd_valid_o && bus.engine_cmd_ready_i) begin
            if (cmd_q.size() == 0) begin
                check("cmd_unexpected", 128'(cmd_q.size()), 128'd1);
            end else begin
                e = cmd_q.pop_front();
                check("issue_id", bus.engine_cmd_id_o, e.id);
                check("issue_data", bus.engine_cmd_data_o, e.data);
            end
        end
        if (bus.cmd_resp_valid_o) begin
            if (resp_q.size() == 0) check("resp_unexpected", 128'(resp_q.size()), 128'd1);
            else check("resp_id", bus.cmd_resp_id_o, resp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of the test sequence");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned order [8] = '{0, 3, 5, 0, 3, 5, 0, 3};
        for (int i = 0; i < N; i++) exp_seq[i] = 8'd0;
        bus.hpu_cmd_valid_i     = '0;
        bus.engine_cmd_ready_i  = 1'b0;
        bus.engine_resp_valid_i = 1'b0;
        bus.engine_resp_id_i    = '0;

        // reset values
        cyc(3);
        check("rst_valid", bus.engine_cmd_valid_o, 1'b0);
        check("rst_id", bus.engine_cmd_id_o, 0);
        check("rst_data", bus.engine_cmd_data_o, 0);
        check("rst_resp_valid", bus.cmd_resp_valid_o, 1'b0);
        check("rst_resp_id", bus.cmd_resp_id_o, 0);
        check("rst_idle", bus.hpu_idle_o, 8'hFF);
        check("rst_outstanding", bus.outstanding_o, 0);
        check("rst_err", bus.err_o, 1'b0);
        rst_n = 1'b1;
        cyc(2);
        check("idle_ready", bus.hpu_cmd_ready_o, 8'h00);
        check("idle_hpu_idle", bus.hpu_idle_o, 8'hFF);

        // HPUs 0,3,5 saturate the credit limit
        foreach (order[k]) push_cmd(order[k]);
        bus.engine_cmd_ready_i = 1'b1;
        bus.hpu_cmd_valid_i    = 8'b0010_1001;
        cyc(14);
        check("full_outstanding", bus.outstanding_o, 8);
        check("full_valid", bus.engine_cmd_valid_o, 1'b0);
        check("full_ready", bus.hpu_cmd_ready_o, 8'h00);
        check("full_idle", bus.hpu_idle_o, 8'hD6);
        check("full_q_empty", 128'(cmd_q.size()), 0);

        // one completion frees one credit; next grant continues after HPU3
        push_cmd(5);
        resp(CL, 3, 8'h77, 1'b1);
        check("c1_outstanding", bus.outstanding_o, 7);
        check("c1_resp_valid", bus.cmd_resp_valid_o, 1'b1);
        check("c1_grant", bus.hpu_cmd_ready_o, 8'b0010_0000);
        cyc(4);
        check("c1_refill", bus.outstanding_o, 8);
        check("c1_ready", bus.hpu_cmd_ready_o, 8'h00);
        check("c1_q_empty", 128'(cmd_q.size()), 0);

        // drain: HPU0 x3, HPU3 x2, HPU5 x3
        bus.hpu_cmd_valid_i = '0;
        for (int k = 0; k < 3; k++) resp(CL, 0, 8'(8'h30 + k), 1'b1);
        for (int k = 0; k < 2; k++) resp(CL, 3, 8'(8'h40 + k), 1'b1);
        for (int k = 0; k < 3; k++) resp(CL, 5, 8'(8'h50 + k), 1'b1);
        cyc(2);
        check("drain_outstanding", bus.outstanding_o, 0);
        check("drain_idle", bus.hpu_idle_o, 8'hFF);
        check("drain_err", bus.err_o, 1'b0);

        // engine backpressure with HPU2 loaded
        push_cmd(2);
        bus.engine_cmd_ready_i = 1'b0;
        bus.hpu_cmd_valid_i    = 8'h04;
        cyc(1);
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", bus.engine_cmd_valid_o, 1'b1);
            check("stall_id", bus.engine_cmd_id_o, mk_id(2, 8'd0));
            check("stall_data", bus.engine_cmd_data_o, mk_data(2, 8'd0));
            check("stall_ready", bus.hpu_cmd_ready_o, 8'h00);
            cyc(1);
        end
        bus.engine_cmd_ready_i = 1'b1;
        bus.hpu_cmd_valid_i    = '0;
        cyc(1);
        check("stall_outstanding", bus.outstanding_o, 1);
        check("stall_idle", bus.hpu_idle_o, 8'hFB);
        check("stall_drained", bus.engine_cmd_valid_o, 1'b0);
        cyc(2);
        check("stall_once", bus.outstanding_o, 1);
        resp(CL, 2, 8'h20, 1'b1);
        check("stall_done", bus.outstanding_o, 0);

        // issue and completion for HPU1 in the same cycle
        push_cmd(1);
        push_cmd(1);
        bus.engine_cmd_ready_i = 1'b0;
        bus.hpu_cmd_valid_i    = 8'h02;
        cyc(1);
        bus.engine_cmd_ready_i = 1'b1;
        cyc(1);
        check("same_pre", bus.outstanding_o, 1);
        bus.hpu_cmd_valid_i = '0;
        resp(CL, 1, 8'h10, 1'b1);
        check("same_outstanding", bus.outstanding_o, 1);
        check("same_idle", bus.hpu_idle_o, 8'hFD);
        check("same_err", bus.err_o, 1'b0);

        // dropped completions: foreign cluster, then with nothing outstanding
        resp(FOREIGN, 1, 8'h01, 1'b0);
        check("foreign_outstanding", bus.outstanding_o, 1);
        check("foreign_err", bus.err_o, 1'b1);
        check("foreign_no_resp", bus.cmd_resp_valid_o, 1'b0);
        resp(CL, 1, 8'h02, 1'b1);
        check("last_outstanding", bus.outstanding_o, 0);
        check("last_idle", bus.hpu_idle_o, 8'hFF);
        resp(CL, 1, 8'h03, 1'b0);
        check("empty_outstanding", bus.outstanding_o, 0);
        check("empty_no_resp", bus.cmd_resp_valid_o, 1'b0);
        check("err_sticky", bus.err_o, 1'b1);
        cyc(2);

        // asynchronous reset with a command held in the register
        bus.engine_cmd_ready_i = 1'b0;
        bus.hpu_cmd_valid_i    = 8'h10;
        cyc(1);
        check("mid_valid", bus.engine_cmd_valid_o, 1'b1);
        check("mid_id", bus.engine_cmd_id_o, mk_id(4, 8'd0));
        bus.hpu_cmd_valid_i = '0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", bus.engine_cmd_valid_o, 1'b0);
        check("arst_id", bus.engine_cmd_id_o, 0);
        check("arst_err", bus.err_o, 1'b0);
        check("arst_outstanding", bus.outstanding_o, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        check("end_cmd_q", 128'(cmd_q.size()), 0);
        check("end_resp_q", 128'(resp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
